alu_bist_engine: RTL

- Synthesizable built-in self-test engine that drives the 8-bit signed ALU through its enable/opcode/operand interface.
- Sweeps every operand pair for each selected opcode and compares the ALU result against an internal golden model.
- Reports done, pass, error count and the first failing vector.
- Sits beside the ALU inside the tensor core. Supplies on-silicon coverage that otherwise exists only as a simulation bench.

---
 rtl/alu_bist_if.sv | 20 ++
 rtl/alu_bist_engine.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_if.sv
// Link between the BIST engine and the 8-bit signed ALU it exercises.
interface alu_bist_if;
    logic       alu_enable_out;
    logic [2:0] alu_opcode_out;
    logic [7:0] alu_input1_out;
    logic [7:0] alu_input2_out;
    logic [7:0] alu_result_in;

    // Engine side: drives the ALU, listens to its result
    modport master (
        output alu_enable_out, alu_opcode_out, alu_input1_out, alu_input2_out,
        input  alu_result_in
    );

    // ALU side
    modport slave (
        input  alu_enable_out, alu_opcode_out, alu_input1_out, alu_input2_out,
        output alu_result_in
    );
endinterface

// File: rtl/alu_bist_engine.sv
// Built-in self-test engine for the 8-bit signed ALU. Sweeps every A/B pair for
// each enabled opcode, checks the ALU result against a golden model carried
// down a latency-matched pipeline, and records pass/fail plus the first bad vector.
module alu_bist_engine #(
    parameter int ALU_LATENCY = 1,
    parameter int ERR_W       = 16
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic             abort_in,
    input  logic [4:0]       op_mask_in,
    alu_bist_if.master       alu,
    output logic             busy_out,
    output logic             done_out,
    output logic             pass_out,
    output logic [ERR_W-1:0] error_count_out,
    output logic             fail_valid_out,
    output logic [2:0]       fail_opcode_out,
    output logic [7:0]       fail_a_out,
    output logic [7:0]       fail_b_out,
    output logic [7:0]       fail_got_out,
    output logic [7:0]       fail_exp_out
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // Every registered output lives here so reset/abort/start can clear it in one go
    typedef struct packed {
        logic             busy;
        logic             done;
        logic             pass;
        logic [2:0]       op;
        logic [7:0]       a;
        logic [7:0]       b;
        logic [ERR_W-1:0] err;
        logic             fvld;
        logic [2:0]       fop;
        logic [7:0]       fa, fb, fgot, fexp;
    } regs_t;

    // One in-flight vector: its identity and the result the ALU should return
    typedef struct packed {
        logic       vld;
        logic [2:0] op;
        logic [7:0] a, b, exp;
    } stage_t;

    state_t                   r_state;
    logic [4:0]               r_mask;
    logic [2:0]               r_drain;
    regs_t                    r_q;
    stage_t [ALU_LATENCY-1:0] r_pipe;

    stage_t     w_head;
    stage_t     w_tail;
    logic [3:0] w_first;
    logic [3:0] w_next;
    logic       w_last;
    logic       w_mis;

    // Low 8 bits of a product do not depend on signedness, so a plain 8-bit
    // multiply gives the signed result's low byte.
    function automatic logic [7:0] golden(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    golden = a + b;
            3'd1:    golden = a - b;
            3'd2:    golden = a * b;
            3'd3:    golden = {7'd0, a == b};
            3'd4:    golden = {7'd0, $signed(a) > $signed(b)};
            default: golden = 8'h00;
        endcase
    endfunction

    // Lowest enabled opcode >= from; bit 3 set means none left
    function automatic logic [3:0] first_op(input logic [4:0] m, input int from);
        first_op = 4'b1000;
        for (int i = 4; i >= 0; i--)
            if (m[i] && i >= from) first_op = {1'b0, i[2:0]};
    endfunction

    assign w_first = first_op(op_mask_in, 0);
    assign w_next  = first_op(r_mask, int'(r_q.op) + 1);
    assign w_last  = (r_q.a == 8'h7F) && (r_q.b == 8'h7F) && w_next[3];
    assign w_tail  = r_pipe[ALU_LATENCY-1];
    assign w_mis   = w_tail.vld && (alu.alu_result_in != w_tail.exp);

    // Expected value for the vector currently on the ALU inputs
    always_comb begin
        w_head     = '0;
        w_head.vld = (r_state == S_RUN);
        w_head.op  = r_q.op;
        w_head.a   = r_q.a;
        w_head.b   = r_q.b;
        w_head.exp = golden(r_q.op, r_q.a, r_q.b);
    end

    // Sequencer FSM, golden pipeline and checker; abort acts as a synchronous clear
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_drain <= '0;
            r_q     <= '0;
            r_pipe  <= '0;
        end else if (abort_in) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_drain <= '0;
            r_q     <= '0;
            r_pipe  <= '0;
        end else begin
            r_pipe[0] <= w_head;
            for (int i = 1; i < ALU_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];

            if (w_mis) begin
                if (r_q.err != '1) r_q.err <= r_q.err + ERR_W'(1);
                if (!r_q.fvld) begin
                    r_q.fvld <= 1'b1;
                    r_q.fop  <= w_tail.op;
                    r_q.fa   <= w_tail.a;
                    r_q.fb   <= w_tail.b;
                    r_q.fgot <= alu.alu_result_in;
                    r_q.fexp <= w_tail.exp;
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_in) begin
                        r_mask <= op_mask_in;
                        r_q    <= '0;
                        r_q.a  <= 8'h80;
                        r_q.b  <= 8'h80;
                        r_q.op <= w_first[2:0];
                        if (w_first[3]) begin
                            r_state  <= S_DONE;
                            r_q.done <= 1'b1;
                            r_q.pass <= 1'b1;
                        end else begin
                            r_state  <= S_RUN;
                            r_q.busy <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_state <= S_DRAIN;
                        r_drain <= 3'(ALU_LATENCY);
                    end else begin
                        r_q.b <= r_q.b + 8'd1;
                        if (r_q.b == 8'h7F) begin
                            r_q.a <= r_q.a + 8'd1;
                            if (r_q.a == 8'h7F) r_q.op <= w_next[2:0];
                        end
                    end
                end
                S_DRAIN: begin
                    // Held one edge past the last check so pass sees the final count
                    if (r_drain == '0) begin
                        r_state  <= S_DONE;
                        r_q.busy <= 1'b0;
                        r_q.done <= 1'b1;
                        r_q.pass <= (r_q.err == '0) && !w_mis;
                    end else begin
                        r_drain <= r_drain - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu.alu_enable_out = r_q.busy;
    assign alu.alu_opcode_out = r_q.op;
    assign alu.alu_input1_out = r_q.a;
    assign alu.alu_input2_out = r_q.b;
    assign busy_out           = r_q.busy;
    assign done_out           = r_q.done;
    assign pass_out           = r_q.pass;
    assign error_count_out    = r_q.err;
    assign fail_valid_out     = r_q.fvld;
    assign fail_opcode_out    = r_q.fop;
    assign fail_a_out         = r_q.fa;
    assign fail_b_out         = r_q.fb;
    assign fail_got_out       = r_q.fgot;
    assign fail_exp_out       = r_q.fexp;
endmodule
